// File: rtl/demux_param_buf_pkg.sv
// Shared constants for the buffered lane demux: drop counter width and saturation value.
package demux_param_buf_pkg;
    localparam int              DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_SAT = 8'hFF;
endpackage

// File: rtl/skid_buf_2.sv
// Two-entry FIFO used as the input skid buffer; ready depends only on registered occupancy.
module skid_buf_2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop,
    output logic [W-1:0] pop_data
);
    logic [1:0][W-1:0] mem;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              push_fire;
    logic              pop_fire;

    assign push_ready = (count != 2'd2);
    assign pop_valid  = (count != 2'd0);
    assign pop_data   = mem[rd_ptr];
    assign push_fire  = push_valid & push_ready;
    assign pop_fire   = pop & pop_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_fire) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_fire)
                rd_ptr <= ~rd_ptr;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/demux_param_buf.sv
// Buffered, handshaked 1-to-SIZE lane demux: skid buffer feeding per-lane output registers,
// strictly in-order dispatch; out-of-range selects are dropped and counted.
module demux_param_buf
    import demux_param_buf_pkg::*;
#(
    parameter int BITS  = 2,
    parameter int SIZE  = 4,
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [BITS-1:0]         in_select,
    output logic [SIZE-1:0]         out_valid,
    input  logic [SIZE-1:0]         out_ready,
    output logic [SIZE*WIDTH-1:0]   out_data,
    output logic                    bad_select,
    output logic [DROP_W-1:0]       drop_count
);
    localparam int EW = WIDTH + BITS;

    logic [EW-1:0]               head;
    logic                        head_valid;
    logic [BITS-1:0]             head_sel;
    logic [WIDTH-1:0]            head_data;
    logic                        pop;
    logic [SIZE-1:0]             sel_hit;
    logic                        in_range;
    logic                        lane_free;
    logic                        dispatch;
    logic                        drop;
    logic [SIZE-1:0][WIDTH-1:0]  lane_data;
    logic [SIZE-1:0]             lane_valid;

    skid_buf_2 #(.W(EW)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({in_select, in_data}),
        .pop_valid  (head_valid),
        .pop        (pop),
        .pop_data   (head)
    );

    assign head_sel  = head[EW-1 -: BITS];
    assign head_data = head[WIDTH-1:0];

    // Decode against each real lane so selects >= SIZE simply match nothing.
    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < SIZE; i++)
            sel_hit[i] = (head_sel == BITS'(i));
    end

    assign in_range  = |sel_hit;
    assign lane_free = |(sel_hit & (~lane_valid | out_ready));
    assign dispatch  = head_valid & in_range & lane_free;
    assign drop      = head_valid & ~in_range;
    assign pop       = dispatch | drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_valid <= '0;
            lane_data  <= '0;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (dispatch && sel_hit[i]) begin
                    lane_valid[i] <= 1'b1;
                    lane_data[i]  <= head_data;
                end else if (out_ready[i]) begin
                    lane_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_select <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            bad_select <= 1'b1;
            if (drop_count != DROP_SAT)
                drop_count <= drop_count + 1'b1;
        end
    end

    assign out_valid = lane_valid;
    assign out_data  = lane_data;
endmodule

// File: tb/tb_demux_param_buf.sv
// Scoreboarded bench: main 4-lane instance plus a 3-lane drop instance and a single-lane instance.
module tb_demux_param_buf;
    logic clk;
    logic rst_n;
    int   cyc;
    int   nvec;
    int   nerr;

    // Instance A: BITS=2 SIZE=4 WIDTH=8
    logic        a_in_valid, a_in_ready;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_select;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [31:0] a_out_data;
    logic        a_bad;
    logic [7:0]  a_drop;

    // Instance B: BITS=2 SIZE=3 WIDTH=8
    logic        b_in_valid, b_in_ready;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_select;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [23:0] b_out_data;
    logic        b_bad;
    logic [7:0]  b_drop;
    bit          b_seen;

    // Instance C: BITS=1 SIZE=1 WIDTH=8
    logic        c_in_valid, c_in_ready;
    logic [7:0]  c_in_data;
    logic        c_in_select;
    logic        c_out_valid, c_out_ready;
    logic [7:0]  c_out_data;
    logic        c_bad;
    logic [7:0]  c_drop;

    typedef struct {
        logic [7:0] d;
        int         t;
    } exp_t;

    exp_t q[4][$];
    exp_t mon_e;

    demux_param_buf #(.BITS(2), .SIZE(4), .WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_select(a_in_select), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .bad_select(a_bad),
        .drop_count(a_drop));

    demux_param_buf #(.BITS(2), .SIZE(3), .WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_select(b_in_select), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .bad_select(b_bad),
        .drop_count(b_drop));

    demux_param_buf #(.BITS(1), .SIZE(1), .WIDTH(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_select(c_in_select), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .bad_select(c_bad),
        .drop_count(c_drop));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Lane monitor for instance A: every completed output handshake pops the lane queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (a_out_valid[i] && a_out_ready[i]) begin
                    nvec++;
                    if (q[i].size() == 0) begin
                        nerr++;
                        $display("FAIL lane%0d_unexpected: got %0h want nothing (cyc %0d)",
                                 i, a_out_data[8*i +: 8], cyc);
                    end else begin
                        mon_e = q[i].pop_front();
                        if (a_out_data[8*i +: 8] !== mon_e.d || (mon_e.t >= 0 && cyc != mon_e.t)) begin
                            nerr++;
                            $display("FAIL lane%0d_word: got %0h@%0d want %0h@%0d",
                                     i, a_out_data[8*i +: 8], cyc, mon_e.d, mon_e.t);
                        end
                    end
                end
            end
            if (|b_out_valid) b_seen = 1'b1;
        end
    end

    task automatic send_a(input logic [7:0] d, input logic [1:0] s, input bit timed);
        bit   done;
        exp_t e;
        done = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = d;
        a_in_select = s;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (a_in_ready) begin
                e.d = d;
                e.t = timed ? cyc + 2 : -1;
                q[s].push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles want accept of %0h", d);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    int c0;

    initial begin
        cyc = 0; nvec = 0; nerr = 0; b_seen = 1'b0;
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_in_select = 0; a_out_ready = 4'hF;
        b_in_valid = 0; b_in_data = 0; b_in_select = 0; b_out_ready = 3'h7;
        c_in_valid = 0; c_in_data = 0; c_in_select = 0; c_out_ready = 1'b1;

        @(negedge clk); @(negedge clk);
        chk("rst_in_ready",  a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data",  a_out_data, 0);
        chk("rst_b_bad",     b_bad, 0);
        chk("rst_b_drop",    b_drop, 0);
        rst_n = 1'b1;
        step(2);

        // Back-to-back stream, one word per lane, one-cycle latency each
        c0 = cyc;
        send_a(8'h11, 2'd0, 1'b1);
        send_a(8'h22, 2'd1, 1'b1);
        send_a(8'h33, 2'd2, 1'b1);
        send_a(8'h44, 2'd3, 1'b1);
        chk("stream_b2b_cycles", cyc - c0, 4);
        @(negedge clk);
        chk("stream_in_ready", a_in_ready, 1);
        step(4);

        // Head-of-line blocking behind a stalled lane 2
        a_out_ready = 4'b1011;
        send_a(8'hA0, 2'd2, 1'b0);
        send_a(8'hA1, 2'd2, 1'b0);
        send_a(8'hA2, 2'd0, 1'b0);
        @(negedge clk);
        chk("bp_in_ready_low", a_in_ready, 0);
        chk("bp_lane0_blocked", a_out_valid[0], 0);
        chk("bp_lane2_hold", a_out_data[23:16], 8'hA0);
        step(1);
        @(negedge clk);
        chk("bp_lane0_still_blocked", a_out_valid[0], 0);
        chk("bp_lane2_still_hold", a_out_data[23:16], 8'hA0);
        step(1);
        a_out_ready = 4'hF;
        step(1);
        @(negedge clk);
        chk("bp_lane2_next", a_out_data[23:16], 8'hA1);
        chk("bp_lane0_in_order", a_out_valid[0], 0);
        step(4);

        // Lane 1 drains and refills on the same edge
        send_a(8'h55, 2'd1, 1'b1);
        send_a(8'h66, 2'd1, 1'b1);
        step(5);
        for (int i = 0; i < 4; i++) chk($sformatf("drained_q%0d", i), q[i].size(), 0);

        // Instance B: out-of-range selects dropped and counted, saturating
        b_in_valid = 1'b1; b_in_data = 8'h77; b_in_select = 2'd3;
        step(1);
        b_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b_bad_first", b_bad, 1);
        chk("b_drop_first", b_drop, 1);
        step(1);
        b_in_valid = 1'b1;
        step(300);
        b_in_valid = 1'b0;
        step(3);
        chk("b_drop_sat", b_drop, 8'd255);
        chk("b_bad_sticky", b_bad, 1);
        chk("b_no_valid", b_seen, 0);

        // Instance C: single lane
        c_in_valid = 1'b1; c_in_data = 8'h5A; c_in_select = 1'b0;
        step(1);
        c_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("c_valid", c_out_valid, 1);
        chk("c_data", c_out_data, 8'h5A);
        chk("c_bad_clear", c_bad, 0);
        step(1);
        c_in_valid = 1'b1; c_in_data = 8'hBB; c_in_select = 1'b1;
        step(1);
        c_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("c_drop_valid", c_out_valid, 0);
        chk("c_drop_bad", c_bad, 1);
        chk("c_drop_count", c_drop, 1);
        step(1);

        // Async reset with lane 0 full and two words buffered behind it
        a_out_ready = 4'h0;
        send_a(8'h01, 2'd0, 1'b0);
        send_a(8'h02, 2'd0, 1'b0);
        send_a(8'h03, 2'd0, 1'b0);
        @(negedge clk);
        chk("pre_rst_full", a_in_ready, 0);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        #1;
        chk("mid_rst_in_ready", a_in_ready, 1);
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_out_data", a_out_data, 0);
        chk("mid_rst_b_bad", b_bad, 0);
        chk("mid_rst_b_drop", b_drop, 0);
        chk("mid_rst_c_bad", c_bad, 0);
        #1 rst_n = 1'b1;
        a_out_ready = 4'hF;
        step(5);
        @(negedge clk);
        chk("post_rst_no_stale", a_out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
